// File: rtl/conv_filter_scheduler.sv
// Steps the 3x3 conv engine through every filter of a layer: loads nine weights
// per filter from kernel memory, runs one engine pass, and relocates its writes.
module conv_filter_scheduler #(
  parameter int NUM_FILTERS = 4,
  parameter int H           = 28,
  parameter int W           = 28,
  parameter int OUT_SIZE    = (H - 2) * (W - 2),
  parameter int KMEM_AW     = 9,
  parameter int OUT_AW      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [5:0]         filter_idx,
  output logic [KMEM_AW-1:0] kmem_addr,
  input  logic [7:0]         kmem_rdata,
  output logic [7:0]         kernel0,
  output logic [7:0]         kernel1,
  output logic [7:0]         kernel2,
  output logic [7:0]         kernel3,
  output logic [7:0]         kernel4,
  output logic [7:0]         kernel5,
  output logic [7:0]         kernel6,
  output logic [7:0]         kernel7,
  output logic [7:0]         kernel8,
  output logic               conv,
  input  logic               eng_done,
  input  logic               eng_store,
  input  logic [9:0]         eng_addr,
  input  logic [31:0]        eng_result,
  output logic               out_we,
  output logic [OUT_AW-1:0]  out_addr,
  output logic [31:0]        out_data
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, NEXT, FIN} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] k;
  logic [7:0] kernel_q [9];
  logic       last_filter;
  logic       store_hit;

  assign last_filter = (filter_idx == 6'(NUM_FILTERS - 1));
  assign store_hit   = (state == RUN) && eng_store;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (k == 4'd9) state_next = ARM;
      ARM:     state_next = RUN;
      RUN:     if (eng_done) state_next = NEXT;
      NEXT:    state_next = last_filter ? FIN : LOAD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      filter_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k          <= '0;
          filter_idx <= '0;
        end
        LOAD: k <= k + 4'd1;
        NEXT: begin
          k <= '0;
          if (!last_filter) filter_idx <= filter_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory read data lags its address by one cycle, so weight i lands when k == i+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) kernel_q[i] <= '0;
    end else if (state == LOAD) begin
      for (int i = 0; i < 9; i++)
        if (k == 4'(i + 1)) kernel_q[i] <= kmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_we <= store_hit;
      if (store_hit) begin
        out_addr <= OUT_AW'(filter_idx) * OUT_AW'(OUT_SIZE) + OUT_AW'(eng_addr);
        out_data <= eng_result;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign conv = (state == RUN);

  assign kmem_addr = (state == LOAD && k < 4'd9)
                     ? KMEM_AW'(filter_idx) * KMEM_AW'(9) + KMEM_AW'(k)
                     : '0;

  assign kernel0 = kernel_q[0];
  assign kernel1 = kernel_q[1];
  assign kernel2 = kernel_q[2];
  assign kernel3 = kernel_q[3];
  assign kernel4 = kernel_q[4];
  assign kernel5 = kernel_q[5];
  assign kernel6 = kernel_q[6];
  assign kernel7 = kernel_q[7];
  assign kernel8 = kernel_q[8];

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench for conv_filter_scheduler: kernel memory holds addr+1, the engine
// is driven by hand, and relocated writes are checked by a queue-based scoreboard.
module tb_conv_filter_scheduler;

  localparam int NF  = 3;
  localparam int OS  = 676;
  localparam int KAW = 9;
  localparam int OAW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [5:0]      filter_idx;
  logic [KAW-1:0]  kmem_addr;
  logic [7:0]      kmem_rdata;
  logic [7:0]      kern [9];
  logic            conv;
  logic            eng_done;
  logic            eng_store;
  logic [9:0]      eng_addr;
  logic [31:0]     eng_result;
  logic            out_we;
  logic [OAW-1:0]  out_addr;
  logic [31:0]     out_data;

  typedef struct {
    logic [OAW-1:0] addr;
    logic [31:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  checks = 0;
  int  errors = 0;

  conv_filter_scheduler #(
    .NUM_FILTERS(NF), .H(28), .W(28), .OUT_SIZE(OS), .KMEM_AW(KAW), .OUT_AW(OAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .filter_idx(filter_idx), .kmem_addr(kmem_addr), .kmem_rdata(kmem_rdata),
    .kernel0(kern[0]), .kernel1(kern[1]), .kernel2(kern[2]),
    .kernel3(kern[3]), .kernel4(kern[4]), .kernel5(kern[5]),
    .kernel6(kern[6]), .kernel7(kern[7]), .kernel8(kern[8]),
    .conv(conv), .eng_done(eng_done), .eng_store(eng_store),
    .eng_addr(eng_addr), .eng_result(eng_result),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Kernel memory model: word at address a holds a+1, one-cycle read latency.
  always @(posedge clk) kmem_rdata <= 8'(kmem_addr) + 8'd1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (out_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 out_addr, out_data);
      end else begin
        exp_w = exp_q.pop_front();
        checkOutput("write_addr", 32'(out_addr), 32'(exp_w.addr));
        checkOutput("write_data", out_data, exp_w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic store, input logic [9:0] addr,
                               input logic [31:0] res, input logic dn);
    start      = st;
    eng_store  = store;
    eng_addr   = addr;
    eng_result = res;
    eng_done   = dn;
    tick();
    start      = 1'b0;
    eng_store  = 1'b0;
    eng_addr   = '0;
    eng_result = '0;
    eng_done   = 1'b0;
  endtask

  task automatic issueStore(input int f, input int a, input logic dn);
    logic [31:0] d;
    d = 32'hC0DE_0000 + 32'(f * 4096 + a);
    exp_q.push_back('{addr: OAW'(f * OS + a), data: d});
    applyStimulus(1'b0, 1'b1, 10'(a), d, dn);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_conv"}, 32'(conv), 0);
    checkOutput({tag, "_out_we"}, 32'(out_we), 0);
    checkOutput({tag, "_filter_idx"}, 32'(filter_idx), 0);
    checkOutput({tag, "_kmem_addr"}, 32'(kmem_addr), 0);
    checkOutput({tag, "_out_addr"}, 32'(out_addr), 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    for (int i = 0; i < 9; i++) checkOutput({tag, "_kernel"}, 32'(kern[i]), 0);
  endtask

  // Called on the first LOAD cycle; returns on the first RUN cycle.
  task automatic loadFilter(input int f, input bit poke);
    checkOutput("load_filter_idx", 32'(filter_idx), 32'(f));
    checkOutput("load_busy", 32'(busy), 1);
    for (int kk = 0; kk < 9; kk++) begin
      checkOutput("load_kmem_addr", 32'(kmem_addr), 32'(f * 9 + kk));
      if (poke && kk == 2) begin
        applyStimulus(1'b1, 1'b1, 10'd4, 32'h1111, 1'b1);
        checkOutput("load_gate_we", 32'(out_we), 0);
      end else begin
        tick();
      end
    end
    tick();
    for (int i = 0; i < 9; i++) checkOutput("arm_kernel", 32'(kern[i]), 32'(f * 9 + i + 1));
    checkOutput("arm_conv", 32'(conv), 0);
    checkOutput("arm_kmem_addr", 32'(kmem_addr), 0);
    tick();
    checkOutput("run_conv", 32'(conv), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eng_done = 1'b0; eng_store = 1'b0;
    eng_addr = '0; eng_result = '0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;

    applyStimulus(1'b0, 1'b1, 10'd3, 32'hDEAD, 1'b1);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_out_we", 32'(out_we), 0);

    applyStimulus(1'b1, 1'b0, 10'd0, 32'h0, 1'b0);
    loadFilter(0, 1'b1);

    applyStimulus(1'b1, 1'b0, 10'd0, 32'h0, 1'b0);
    checkOutput("run_start_conv", 32'(conv), 1);
    checkOutput("run_start_idx", 32'(filter_idx), 0);
    issueStore(0, 0, 1'b0);
    issueStore(0, 675, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    checkOutput("next0_conv", 32'(conv), 0);
    checkOutput("next0_done", 32'(done), 0);
    tick();

    loadFilter(1, 1'b0);
    issueStore(1, 0, 1'b0);
    issueStore(1, 675, 1'b0);
    issueStore(1, 5, 1'b1);
    checkOutput("next1_conv", 32'(conv), 0);
    checkOutput("next1_idx", 32'(filter_idx), 1);
    tick();
    checkOutput("after_next1_idx", 32'(filter_idx), 2);

    loadFilter(2, 1'b0);
    issueStore(2, 0, 1'b0);
    issueStore(2, 675, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    checkOutput("next2_done", 32'(done), 0);
    checkOutput("next2_conv", 32'(conv), 0);
    tick();
    checkOutput("fin_done", 32'(done), 1);
    checkOutput("fin_busy", 32'(busy), 1);
    tick();
    checkOutput("idle_done", 32'(done), 0);
    checkOutput("idle_busy_end", 32'(busy), 0);
    checkOutput("idle_idx_hold", 32'(filter_idx), 2);

    applyStimulus(1'b1, 1'b0, 10'd0, 32'h0, 1'b0);
    loadFilter(0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    tick();
    loadFilter(1, 1'b0);
    issueStore(1, 7, 1'b0);
    checkOutput("pre_reset_we", 32'(out_we), 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'd8, 32'hBAD, 1'b0);
    checkResetValues("midrun_reset");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd0, 32'h0, 1'b0);
    checkOutput("restart_kmem_addr", 32'(kmem_addr), 0);
    checkOutput("restart_idx", 32'(filter_idx), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_filter_scheduler.md
# conv_filter_scheduler

Sequences the 3x3 convolution engine across a bank of filters for one input feature map. On `start`, for each filter in turn it fetches that filter's nine 8-bit weights from a kernel memory into stable kernel registers and runs the engine for one full pass. It relocates each engine output write into a per-filter region of the output feature-map memory. It sits between the layer controller (start/done) and the conv engine plus kernel and output memories.

## Interface
- `NUM_FILTERS`, 4: filters per layer, range 1..64.
- `H`, 28: input height, forwarded to engine geometry.
- `W`, 28: input width.
- `OUT_SIZE`, (H-2)*(W-2) = 676: outputs per filter.
- `KMEM_AW`, 9: kernel memory address width; must hold 9*NUM_FILTERS.
- `OUT_AW`, 12: output memory address width; must hold NUM_FILTERS*OUT_SIZE.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to process all filters.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, out, 1: one-cycle pulse after the last filter completes.
- `filter_idx`, out, 6: index of the filter currently being loaded or run.
- `kmem_addr`, out, KMEM_AW: kernel memory read address.
- `kmem_rdata`, in, 8: kernel memory data, valid one cycle after its address.
- `kernel0`..`kernel8`, out, 8 each: weights driven to the engine, row-major.
- `conv`, out, 1: engine run level.
- `eng_done`, in, 1: engine pass complete.
- `eng_store`, in, 1: engine output valid.
- `eng_addr`, in, 10: engine output address.
- `eng_result`, in, 32: engine output data.
- `out_we`, out, 1: output memory write enable.
- `out_addr`, out, OUT_AW: output memory write address.
- `out_data`, out, 32: output memory write data.

## Operation
- The FSM has six states: IDLE, LOAD, ARM, RUN, NEXT, FIN.
- IDLE:
  - `start`=1 resets `filter_idx` to 0 and the weight counter `k` to 0, then moves to LOAD.
  - `start` is ignored in every state other than IDLE.
- LOAD:
  - Cycle k (k = 0..8) drives `kmem_addr` = `filter_idx`*9 + k.
  - Cycle k+1 captures `kmem_rdata` into `kernel<k>`.
  - LOAD lasts 10 cycles, then moves to ARM.
  - `kmem_addr` holds 0 outside LOAD.
- ARM: one cycle, `conv` stays 0, so weights settle before the engine starts; moves to RUN.
- RUN:
  - `conv`=1 for the whole state.
  - Kernel registers are frozen.
  - `eng_done`=1 moves the FSM to NEXT.
- NEXT:
  - `conv`=0 for this cycle, giving the engine a low cycle between passes.
  - If `filter_idx` == NUM_FILTERS-1, move to FIN.
  - Otherwise increment `filter_idx`, clear `k`, and move to LOAD.
- FIN: `done`=1 for one cycle, then move to IDLE. `filter_idx` holds its last value.
- Output relocation:
  - If `eng_store`=1 while in RUN, the next cycle has `out_we`=1, `out_addr` = `filter_idx`*OUT_SIZE + `eng_addr`, and `out_data` = `eng_result`.
  - Arithmetic is unsigned and zero-extended to OUT_AW. No overflow occurs when parameters are legal.
  - `eng_store` outside RUN is dropped, so `out_we` stays 0.
  - `eng_store` and `eng_done` in the same RUN cycle: the write is still issued, using the pre-increment `filter_idx`.
- `eng_done` outside RUN is ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE; `busy`, `done`, `conv`, `out_we` = 0; `filter_idx`, `kmem_addr`, `out_addr`, `out_data` = 0; `kernel0`..`kernel8` = 0.
- `rst` during any state returns to IDLE on the next edge. `conv` drops immediately and no further `out_we` is issued; a write already registered in that cycle is cleared.
- Per-filter overhead outside RUN: LOAD 10 + ARM 1 + NEXT 1 = 12 cycles.
- `start` at cycle 0 gives:
  - `busy`=1 at cycle 1.
  - First `kmem_addr` (0) at cycle 1.
  - `kernel8` valid at cycle 11.
  - ARM at cycle 11, `conv`=1 from cycle 12.
- `done` pulses 2 cycles after the last `eng_done` is sampled (NEXT, then FIN).
- Output write latency is 1 cycle from `eng_store`. Back-to-back stores give back-to-back writes.

## Test plan
- Load: NUM_FILTERS=1; kmem contents 1..9 -> `kmem_addr` steps 0..8 at cycles 1..9; `kernel0..8` = 1..9 at cycle 11; `conv` rises at cycle 12.
- Relocation: NUM_FILTERS=3; engine model issues stores with addr 0 and 675 for each filter -> writes land at 0/675, 676/1351, 1352/2027 with matching data; `done` pulses once, 2 cycles after the third `eng_done`.
- Run-state gating: `start` pulsed during RUN, plus `eng_store`/`eng_done` pulsed during IDLE and LOAD -> no state change, no `out_we`, `filter_idx` unchanged.
- Coincident events: `eng_store` with addr 5 and `eng_done` in the same cycle on filter 1 -> one write to address 681; then `conv` low for exactly one cycle; `filter_idx` becomes 2.
- Reset mid-run: `rst` asserted in RUN of filter 1 -> next cycle all outputs equal their reset values; a fresh `start` restarts from filter 0 with `kmem_addr` 0.
